// File: rtl/alu_share_arbiter_if.sv
// Bundle of requester handshakes, the ALU operand/result bus and the shared
// response/status lines of the ALU share arbiter.
interface alu_share_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 26,
  parameter int CNT_WIDTH  = 16
);
  logic                  req0_valid, req1_valid;
  logic                  req0_ready, req1_ready;
  logic [DATA_WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [OP_WIDTH-1:0]   req0_op, req1_op;
  logic [DATA_WIDTH-1:0] alu_a, alu_b;
  logic [OP_WIDTH-1:0]   alu_op;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  rsp0_valid, rsp1_valid;
  logic                  rsp0_ready, rsp1_ready;
  logic [DATA_WIDTH-1:0] rsp_result;
  logic                  rsp_err;
  logic [CNT_WIDTH-1:0]  issue_count;

  // Requesters plus the ALU itself.
  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
           req0_op, req1_op, rsp0_ready, rsp1_ready, alu_result,
    input  req0_ready, req1_ready, alu_a, alu_b, alu_op,
           rsp0_valid, rsp1_valid, rsp_result, rsp_err, issue_count
  );

  // The arbiter.
  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
           req0_op, req1_op, rsp0_ready, rsp1_ready, alu_result,
    output req0_ready, req1_ready, alu_a, alu_b, alu_op,
           rsp0_valid, rsp1_valid, rsp_result, rsp_err, issue_count
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin front-end sharing one combinational ALU between two requesters:
// accept in IDLE, drive the ALU in EXEC, hold the registered result in RESP.
module alu_share_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 26,
  parameter int CNT_WIDTH  = 16
) (
  input logic               clk,
  input logic               reset,
  alu_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                state_q, state_d;
  logic                  prio_q;
  logic                  owner_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic [OP_WIDTH-1:0]   op_q;
  logic [DATA_WIDTH-1:0] rsp_result_q;
  logic                  rsp_err_q;
  logic [CNT_WIDTH-1:0]  issue_cnt_q;

  logic                  any_valid;
  logic                  grant;
  logic                  handshake;
  logic                  owner_rsp_ready;
  logic [DATA_WIDTH-1:0] sel_a, sel_b;
  logic [OP_WIDTH-1:0]   sel_op;

  // Computational codes of the ALU; branch compares count as computational.
  function automatic logic op_legal(input logic [OP_WIDTH-1:0] op);
    logic [31:0] op32;
    op32 = 32'(op);
    case (op32)
      32'h0000_0001, 32'h0000_0002, 32'h0000_0006, 32'h0000_0008,
      32'h0000_0010, 32'h0000_0020, 32'h0000_0040, 32'h0000_0080,
      32'h0000_0100, 32'h0000_0200, 32'h0000_0400, 32'h0000_0800,
      32'h0000_1000: op_legal = 1'b1;
      default:       op_legal = 1'b0;
    endcase
  endfunction

  // A lone valid requester wins regardless of prio; prio only breaks ties.
  assign any_valid       = bus.req0_valid | bus.req1_valid;
  assign grant           = (bus.req0_valid && bus.req1_valid) ? prio_q : bus.req1_valid;
  assign handshake       = (state_q == IDLE) && any_valid;
  assign owner_rsp_ready = owner_q ? bus.rsp1_ready : bus.rsp0_ready;
  assign sel_a           = grant ? bus.req1_a  : bus.req0_a;
  assign sel_b           = grant ? bus.req1_b  : bus.req0_b;
  assign sel_op          = grant ? bus.req1_op : bus.req0_op;

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_valid) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (owner_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.req0_ready = any_valid && !grant;
        bus.req1_ready = any_valid &&  grant;
      end
      RESP: begin
        bus.rsp0_valid = !owner_q;
        bus.rsp1_valid =  owner_q;
      end
      default: ;
    endcase
  end

  // Operand latch, arbitration pointer, issue counter and result register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      owner_q      <= 1'b0;
      err_q        <= 1'b0;
      prio_q       <= 1'b0;
      issue_cnt_q  <= '0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      if (handshake) begin
        a_q         <= sel_a;
        b_q         <= sel_b;
        op_q        <= sel_op;
        owner_q     <= grant;
        err_q       <= !op_legal(sel_op);
        prio_q      <= !grant;
        issue_cnt_q <= issue_cnt_q + CNT_WIDTH'(1);
      end
      if (state_q == EXEC) begin
        rsp_result_q <= bus.alu_result;
        rsp_err_q    <= err_q;
      end
    end
  end

  // The ALU sees the latched operands continuously; they only change on accept.
  assign bus.alu_a       = a_q;
  assign bus.alu_b       = b_q;
  assign bus.alu_op      = op_q;
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.issue_count = issue_cnt_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: transaction-level model compared
// every cycle, plus directed vectors with hand-computed results.
module tb_alu_share_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  alu_share_arbiter_if #(.DATA_WIDTH(32), .OP_WIDTH(26), .CNT_WIDTH(16)) bus ();

  alu_share_arbiter #(.DATA_WIDTH(32), .OP_WIDTH(26), .CNT_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference ALU; unsigned compares, unknown codes return 0.
  function automatic logic [31:0] alu_ref(input logic [25:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      26'h1:    return a | b;
      26'h2:    return a + b;
      26'h6:    return a - b;
      26'h8:    return a & b;
      26'h10:   return a ^ b;
      26'h20:   return {31'b0, a < b};
      26'h40:   return 32'($signed(a) >>> b[4:0]);
      26'h80:   return a >> b[4:0];
      26'h100:  return a << b[4:0];
      26'h200:  return {31'b0, a == b};
      26'h400:  return {31'b0, a != b};
      26'h800:  return {31'b0, a < b};
      26'h1000: return {31'b0, a >= b};
      default:  return 32'h0;
    endcase
  endfunction

  function automatic logic is_legal(input logic [25:0] op);
    logic [25:0] codes [13];
    codes = '{26'h1, 26'h2, 26'h6, 26'h8, 26'h10, 26'h20, 26'h40, 26'h80,
              26'h100, 26'h200, 26'h400, 26'h800, 26'h1000};
    foreach (codes[i]) if (codes[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic pick(input logic v0, input logic v1, input logic p);
    return (v0 && v1) ? p : v1;
  endfunction

  assign bus.alu_result = alu_ref(bus.alu_op, bus.alu_a, bus.alu_b);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: an op in flight, its age in cycles since acceptance.
  logic        m_pending, m_owner, m_prio, m_err, m_rsp_err;
  int          m_age;
  logic [31:0] m_a, m_b, m_res, m_rsp_res;
  logic [25:0] m_op;
  logic [15:0] m_acc;
  logic [15:0] cnt_base = 16'h0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pending <= 1'b0; m_owner <= 1'b0; m_prio <= 1'b0; m_err <= 1'b0;
      m_rsp_err <= 1'b0; m_age <= 0; m_a <= '0; m_b <= '0; m_op <= '0;
      m_res <= '0; m_rsp_res <= '0; m_acc <= '0;
    end else if (!m_pending) begin
      if (bus.req0_valid || bus.req1_valid) begin
        automatic logic g = pick(bus.req0_valid, bus.req1_valid, m_prio);
        automatic logic [31:0] a  = g ? bus.req1_a  : bus.req0_a;
        automatic logic [31:0] b  = g ? bus.req1_b  : bus.req0_b;
        automatic logic [25:0] op = g ? bus.req1_op : bus.req0_op;
        m_pending <= 1'b1; m_age <= 1; m_owner <= g; m_prio <= !g;
        m_a <= a; m_b <= b; m_op <= op;
        m_res <= alu_ref(op, a, b); m_err <= !is_legal(op);
        m_acc <= m_acc + 16'd1;
      end
    end else if (m_age == 1) begin
      m_age <= 2; m_rsp_res <= m_res; m_rsp_err <= m_err;
    end else if (m_owner ? bus.rsp1_ready : bus.rsp0_ready) begin
      m_pending <= 1'b0;
    end
  end

  // Compare process: every output, every cycle, on the falling edge.
  always @(negedge clk) begin
    automatic logic any = bus.req0_valid || bus.req1_valid;
    automatic logic g   = pick(bus.req0_valid, bus.req1_valid, m_prio);
    automatic logic idle = !m_pending && reset;
    automatic logic resp = m_pending && m_age == 2;
    check("cyc_req0_ready", 32'(bus.req0_ready), 32'(idle && any && !g));
    check("cyc_req1_ready", 32'(bus.req1_ready), 32'(idle && any && g));
    check("cyc_rsp0_valid", 32'(bus.rsp0_valid), 32'(resp && !m_owner));
    check("cyc_rsp1_valid", 32'(bus.rsp1_valid), 32'(resp && m_owner));
    check("cyc_rsp_result", bus.rsp_result, m_rsp_res);
    check("cyc_rsp_err", 32'(bus.rsp_err), 32'(m_rsp_err));
    check("cyc_alu_a", bus.alu_a, m_a);
    check("cyc_alu_b", bus.alu_b, m_b);
    check("cyc_alu_op", 32'(bus.alu_op), 32'(m_op));
    check("cyc_issue_count", 32'(bus.issue_count), 32'(16'(cnt_base + m_acc)));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [25:0] op);
    bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
  endtask

  task automatic drive1(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [25:0] op);
    bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
  endtask

  typedef struct {
    logic [25:0] op;
    logic [31:0] a, b, res;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs = '{'{26'h100, 32'h1, 32'h4, 32'h10},
             '{26'h40, 32'h8000_0000, 32'h4, 32'hF800_0000},
             '{26'h400, 32'h5, 32'h5, 32'h0},
             '{26'h1000, 32'h7, 32'h3, 32'h1},
             '{26'h6, 32'h3, 32'h5, 32'hFFFF_FFFE}};

    reset = 1'b0;
    drive0(1'b0, '0, '0, '0);
    drive1(1'b0, '0, '0, '0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_issue_count", 32'(bus.issue_count), 32'h0);
    check("rst_alu_op", 32'(bus.alu_op), 32'h0);
    check("rst_rsp_result", bus.rsp_result, 32'h0);
    reset = 1'b1;

    // Single ADD from req0.
    drive0(1'b1, 32'd5, 32'd7, 26'h2);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    #1;
    check("add_req0_ready", 32'(bus.req0_ready), 32'h1);
    tick();
    drive0(1'b0, '0, '0, '0);
    check("add_alu_op", 32'(bus.alu_op), 32'h2);
    tick();
    check("add_rsp0_valid", 32'(bus.rsp0_valid), 32'h1);
    check("add_rsp_result", bus.rsp_result, 32'd12);
    check("add_rsp_err", 32'(bus.rsp_err), 32'h0);
    check("add_rsp1_valid", 32'(bus.rsp1_valid), 32'h0);
    tick();

    // Both valid: prio points at req1 after the req0 grant, so 1,0,1,0.
    drive0(1'b1, 32'd10, 32'd3, 26'h6);
    drive1(1'b1, 32'hFFFF_FFFF, 32'd1, 26'h20);
    #1;
    for (int k = 0; k < 4; k++) begin
      automatic logic g = (k % 2 == 0);
      check("rr_req1_ready", 32'(bus.req1_ready), 32'(g));
      check("rr_req0_ready", 32'(bus.req0_ready), 32'(!g));
      check("rr_issue_count", 32'(bus.issue_count), 32'(k + 1));
      tick();
      tick();
      check(g ? "rr_rsp1_valid" : "rr_rsp0_valid",
            32'(g ? bus.rsp1_valid : bus.rsp0_valid), 32'h1);
      check("rr_result", bus.rsp_result, g ? 32'd0 : 32'd7);
      tick();
    end
    drive0(1'b0, '0, '0, '0);
    drive1(1'b0, '0, '0, '0);

    // Backpressure on req1 while req0 waits with an illegal op.
    drive1(1'b1, 32'hF0, 32'hFF, 26'h10);
    bus.rsp1_ready = 1'b0;
    #1;
    check("bp_req1_ready", 32'(bus.req1_ready), 32'h1);
    tick();
    drive1(1'b0, '0, '0, '0);
    drive0(1'b1, 32'd1, 32'd1, 26'h2000);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp1_valid", 32'(bus.rsp1_valid), 32'h1);
      check("bp_rsp_result", bus.rsp_result, 32'h0F);
      check("bp_req0_ready", 32'(bus.req0_ready), 32'h0);
      tick();
    end
    bus.rsp1_ready = 1'b1;
    tick();
    check("bp_idle_req0_ready", 32'(bus.req0_ready), 32'h1);
    tick();
    drive0(1'b0, '0, '0, '0);
    tick();
    check("ill_rsp0_valid", 32'(bus.rsp0_valid), 32'h1);
    check("ill_rsp_result", bus.rsp_result, 32'h0);
    check("ill_rsp_err", 32'(bus.rsp_err), 32'h1);
    tick();

    // Reset while a response is pending.
    drive0(1'b1, 32'd3, 32'd4, 26'h2);
    bus.rsp0_ready = 1'b0;
    tick();
    drive0(1'b0, '0, '0, '0);
    tick();
    check("rr_pre_rsp0_valid", 32'(bus.rsp0_valid), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("arst_rsp0_valid", 32'(bus.rsp0_valid), 32'h0);
    check("arst_issue_count", 32'(bus.issue_count), 32'h0);
    check("arst_alu_op", 32'(bus.alu_op), 32'h0);
    tick();
    reset = 1'b1;
    bus.rsp0_ready = 1'b1;
    drive1(1'b1, 32'hC, 32'hA, 26'h8);
    #1;
    check("post_rst_req1_ready", 32'(bus.req1_ready), 32'h1);
    tick();
    drive1(1'b0, '0, '0, '0);
    tick();
    check("post_rst_rsp1_valid", 32'(bus.rsp1_valid), 32'h1);
    check("post_rst_result", bus.rsp_result, 32'h8);
    tick();

    // Directed op table through req0.
    foreach (vecs[i]) begin
      drive0(1'b1, vecs[i].a, vecs[i].b, vecs[i].op);
      tick();
      drive0(1'b0, '0, '0, '0);
      tick();
      check("vec_result", bus.rsp_result, vecs[i].res);
      check("vec_err", 32'(bus.rsp_err), 32'h0);
      tick();
    end

    // Counter wrap: preload 0xFFFF, then one more accept.
    cnt_base = 16'hFFFF - m_acc;
    force dut.issue_cnt_q = 16'hFFFF;
    tick();
    release dut.issue_cnt_q;
    check("wrap_pre", 32'(bus.issue_count), 32'hFFFF);
    drive0(1'b1, 32'd1, 32'd2, 26'h1);
    tick();
    drive0(1'b0, '0, '0, '0);
    check("wrap_post", 32'(bus.issue_count), 32'h0);
    tick();
    check("wrap_or_result", bus.rsp_result, 32'h3);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
